// File: rtl/mux_lut_gate_pkg.sv
// Shared types and helpers for the programmable mux-tree LUT gate.
package mux_lut_gate_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMMIT
    } lut_state_t;

    // Number of truth-table entries for a k-input function.
    function automatic int unsigned tbl_size(int unsigned k);
        return 2 ** k;
    endfunction

endpackage

// File: rtl/mux_lut_gate_if.sv
// Config and evaluation bundle for mux_lut_gate. The master drives config bits and
// operands; the slave (the gate) returns ready/done and the registered result.
interface mux_lut_gate_if #(
    parameter int unsigned K = 2,
    parameter int unsigned W = 8
);
    logic           cfg_valid;
    logic           cfg_ready;
    logic           cfg_bit;
    logic           cfg_done;
    logic           in_valid;
    logic [K*W-1:0] in_ops;
    logic           out_valid;
    logic [W-1:0]   out_res;

    modport master (
        output cfg_valid, cfg_bit, in_valid, in_ops,
        input  cfg_ready, cfg_done, out_valid, out_res
    );

    modport slave (
        input  cfg_valid, cfg_bit, in_valid, in_ops,
        output cfg_ready, cfg_done, out_valid, out_res
    );
endinterface

// File: rtl/mux_lut_tree.sv
// Single-lane K-level tree of 2:1 muxes. Level i selects on sel_i[i]; the leaves are
// the truth-table entries, so the result is tbl_i[sel_i].
module mux_lut_tree
    import mux_lut_gate_pkg::*;
#(
    parameter int unsigned K = 2
) (
    input  logic [tbl_size(K)-1:0] tbl_i,
    input  logic [K-1:0]           sel_i,
    output logic                   y_o
);
    localparam int unsigned TblSize = tbl_size(K);

    logic [TblSize-1:0] node;

    // Reduce the table level by level in place; node n of level l+1 muxes nodes 2n/2n+1.
    always_comb begin
        node = tbl_i;
        for (int l = 0; l < K; l++) begin
            for (int n = 0; n < TblSize / 2; n++) begin
                if (n < int'(TblSize >> (l + 1))) begin
                    node[n] = sel_i[l] ? node[2*n+1] : node[2*n];
                end
            end
        end
        y_o = node[0];
    end
endmodule

// File: rtl/mux_lut_gate.sv
// Programmable K-input, W-lane bitwise gate. Truth-table bits are shifted in serially into
// a shadow table and committed to the active table in one cycle, so evaluation never stalls.
// Optional macro MUX_LUT_GATE_PIPE2_EN adds a second output register (latency 2).
module mux_lut_gate
    import mux_lut_gate_pkg::*;
#(
    parameter int unsigned K = 2,
    parameter int unsigned W = 8
) (
    input logic           clk,
    input logic           rst,
    mux_lut_gate_if.slave bus
);
    localparam int unsigned TblSize = tbl_size(K);

    lut_state_t         state_q, state_d;
    logic [K-1:0]       cnt_q, cnt_d;
    logic [TblSize-1:0] shadow_q, shadow_d;
    logic [TblSize-1:0] active_q, active_d;
    logic               cfg_done_q, cfg_done_d;
    logic               cfg_ready;
    logic               cfg_accept;

    assign cfg_ready    = (state_q != COMMIT);
    assign cfg_accept   = bus.cfg_valid && cfg_ready;
    assign bus.cfg_ready = cfg_ready;
    assign bus.cfg_done  = cfg_done_q;

    // Config FSM: the counter alone decides when the last table bit has arrived.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shadow_d   = shadow_q;
        active_d   = active_q;
        cfg_done_d = cfg_done_q;
        unique case (state_q)
            IDLE, LOAD: begin
                if (cfg_accept) begin
                    shadow_d[cnt_q] = bus.cfg_bit;
                    if (cnt_q == {K{1'b1}}) begin
                        state_d = COMMIT;
                        cnt_d   = '0;
                    end else begin
                        state_d = LOAD;
                        cnt_d   = cnt_q + K'(1);
                    end
                end
            end
            COMMIT: begin
                active_d   = shadow_q;
                cfg_done_d = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Config state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shadow_q   <= '0;
            active_q   <= '0;
            cfg_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            cfg_done_q <= cfg_done_d;
        end
    end

    // One mux tree per lane, all sharing the active table.
    logic [W-1:0] tree_y;

    for (genvar j = 0; j < W; j++) begin : g_lane
        logic [K-1:0] sel;
        for (genvar i = 0; i < K; i++) begin : g_sel
            assign sel[i] = bus.in_ops[i*W+j];
        end
        mux_lut_tree #(
            .K(K)
        ) u_tree (
            .tbl_i(active_q),
            .sel_i(sel),
            .y_o  (tree_y[j])
        );
    end

    logic         s1_valid_q, s1_valid_d;
    logic [W-1:0] s1_res_q, s1_res_d;

    // Stage 1: inputs arriving before a table is committed are silently dropped.
    always_comb begin
        s1_valid_d = bus.in_valid && cfg_done_q;
        s1_res_d   = s1_valid_d ? tree_y : s1_res_q;
    end

    // Stage 1 registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_res_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_res_q   <= s1_res_d;
        end
    end

`ifdef MUX_LUT_GATE_PIPE2_EN
    logic         s2_valid_q, s2_valid_d;
    logic [W-1:0] s2_res_q, s2_res_d;

    // Stage 2 next state: forward stage 1, hold result when nothing new arrives.
    always_comb begin
        s2_valid_d = s1_valid_q;
        s2_res_d   = s1_valid_q ? s1_res_q : s2_res_q;
    end

    // Stage 2 registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
        end else begin
            s2_valid_q <= s2_valid_d;
            s2_res_q   <= s2_res_d;
        end
    end

    assign bus.out_valid = s2_valid_q;
    assign bus.out_res   = s2_res_q;
`else
    assign bus.out_valid = s1_valid_q;
    assign bus.out_res   = s1_res_q;
`endif
endmodule

// File: doc/mux_lut_gate.md
Name: mux_lut_gate

Overview:
- Programmable K-input, W-lane bitwise logic gate built from a tree of 2:1 muxes. The truth-table constants feeding the tree are loaded at run time, not tied off.
- Sits in the combinational-logic exercise chain as the generalised successor of fixed-function mux-built gates: any K-input function applied lane-wise to W-bit operands.
- Registered output with valid handshake.
- Truth table is double-buffered, so evaluation continues during reprogramming.

Parameters:
- K, default 2: number of operands (mux tree depth); legal range 1..6.
- W, default 8: lane count (bits per operand and result).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- cfg_valid  input  1  cfg_bit is presented this cycle.
- cfg_ready  output  1  block can accept a cfg_bit.
- cfg_bit  input  1  next truth-table bit, entry 0 first.
- cfg_done  output  1  active table holds a complete, committed function.
- in_valid  input  1  operands presented.
- in_ops  input  K*W  operand i occupies in_ops[i*W +: W].
- out_valid  output  1  out_res is valid.
- out_res  output  W  result; lane j = table[{op[K-1][j], ..., op[0][j]}].

Behaviour:
- Reset (clk edge with rst=1): state=IDLE, bit counter=0, shadow and active tables=0, cfg_done=0, out_valid=0, out_res=0. A reset mid-load discards all accepted bits.
- Config handshake: a bit is accepted when cfg_valid && cfg_ready. Cycles with cfg_valid=0 do not advance the counter.
- Accepted bit n (0..2^K-1) is written to shadow[n].
- FSM states:
  - IDLE: cfg_ready=1. An accepted bit moves to LOAD; if K=1 and two bits... see counter rule below.
  - LOAD: cfg_ready=1. The counter increments per accepted bit. Acceptance of bit 2^K-1 moves to COMMIT and clears the counter.
  - COMMIT: one cycle, cfg_ready=0. At the end of this cycle active <= shadow and cfg_done <= 1, then return to IDLE.
- Counter rule: the transition to COMMIT is decided by the counter value, not by the state. A single-bit table cannot occur, since K>=1 gives at least 2 bits.
- Evaluation is a single pipeline stage with latency 1:
  - out_valid(t+1) = in_valid(t) && cfg_done(t).
  - out_res(t+1) = tree(active(t), in_ops(t)).
  - When out_valid is not asserted, out_res holds its last value.
- in_valid while cfg_done=0: the input is dropped, out_valid stays 0, and there is no error flag.
- Reprogramming while cfg_done=1: cfg_done stays 1 and evaluations keep using the old active table through the COMMIT cycle.
- The first evaluation using the new table is an input presented in the cycle after COMMIT.
- Simultaneous cfg and eval traffic is fully independent; there is no back-pressure on the eval path.
- Index bit i of the table lookup comes from operand i. The mux tree level i selects on operand i.

Optional Feature:
- Macro MUX_LUT_GATE_PIPE2_EN.
- When defined: a second register stage is inserted after the mux tree. Latency becomes 2: out_valid(t+2) = in_valid(t) && cfg_done(t). The table is sampled at stage 1.
- When undefined: latency is 1, as above.
- Reset clears both stages.

Decomposition:
- Package mux_lut_gate_pkg holds:
  - typedef enum logic [1:0] {IDLE, LOAD, COMMIT} lut_state_t.
  - Function tbl_size(k) returning 2**k.
- Sub-module mux_lut_tree(K): single-lane combinational tree of 2:1 muxes (table[2^K], sel[K] -> y). It is instantiated W times via generate, and all instances share the active table.

Test Plan:
1. Reset behaviour. K=2, W=8: hold rst 2 cycles, then drive in_valid=1, ops a=8'hF0, b=8'hCC -> out_valid=0, out_res=8'h00, cfg_done=0, cfg_ready=1.
2. AND function. Load bits 0,0,0,1 (table 4'b1000) -> COMMIT lasts one cycle with cfg_ready=0, then cfg_done=1. Evaluate a=F0, b=CC -> next cycle out_valid=1, out_res=8'hC0.
3. Stalled config. Interleave idle cycles (cfg_valid=0) between the 4 bits -> cfg_done rises exactly one cycle after the 4th accepted bit, not earlier.
4. Hot reload. With AND active, stream OR (4'b1110) while evaluating F0/CC every cycle -> results are C0 through the COMMIT cycle, then FC from the next input onward. No out_valid gaps.
5. Reset mid-load. After 2 of 4 bits, pulse rst -> cfg_done=0. A fresh full 4-bit load is required before any out_valid.
6. Majority function. K=3, W=4, table 8'hE8; ops 4'b1100, 4'b1010, 4'b0110 -> out_res=4'b1110. With MUX_LUT_GATE_PIPE2_EN defined, the same result appears 2 cycles after in_valid.
